am_align_seq: RTL

Closed-loop alignment sequencer for one alignment motor axis. Consumes the per-frame correction results of the image-to-step stage (pulse, signed step, ok, should_start) and issues single motor move commands. After each move it waits for the motor to stop and settle, then repeats until the image stage reports ok, the iteration limit is hit, a timeout expires, or software aborts. Sits between the software command registers and the motor pulse generator, one instance per axis.

---
 rtl/am_align_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/am_align_seq.sv
// Closed-loop alignment sequencer for one motor axis: waits for an image result, issues a move,
// waits for run/stop and settle frames, repeats until ok / iteration limit / timeout / abort.
module am_align_seq #(
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_ITER_WIDTH        = 8,
  parameter int C_FRAME_CNT_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           abort,
  input  logic [C_ITER_WIDTH-1:0]        cfg_max_iter,
  input  logic [C_FRAME_CNT_WIDTH-1:0]   cfg_settle_frames,
  input  logic [C_FRAME_CNT_WIDTH-1:0]   cfg_timeout_frames,
  input  logic                           img_pulse,
  input  logic                           am_pulse,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] am_step,
  input  logic                           am_ok,
  input  logic                           am_should_start,
  input  logic                           m_state,
  output logic                           m_start,
  output logic [C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic                           m_stop,
  output logic                           busy,
  output logic                           done,
  output logic                           ok,
  output logic [1:0]                     err_code,
  output logic [C_ITER_WIDTH-1:0]        iter_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RES, ISSUE, WAIT_RUN, WAIT_STOP, SETTLE, FIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ITER    = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  state_t                         state, state_nx;
  logic [C_FRAME_CNT_WIDTH-1:0]   frame_cnt, frame_cnt_nx;
  logic [C_STEP_NUMBER_WIDTH-1:0] step_lat, step_lat_nx;
  logic [C_STEP_NUMBER_WIDTH-1:0] m_step_nx;
  logic [C_ITER_WIDTH-1:0]        iter_nx;
  logic [1:0]                     err_nx;
  logic                           m_start_nx, m_stop_nx, busy_nx, done_nx, ok_nx;
  logic                           timeout_hit, abortable, motor_phase;

  always_comb begin
    state_nx    = state;
    step_lat_nx = step_lat;
    m_start_nx  = 1'b0;
    m_step_nx   = m_step;
    m_stop_nx   = 1'b0;
    done_nx     = 1'b0;
    ok_nx       = ok;
    err_nx      = err_code;
    iter_nx     = iter_cnt;

    timeout_hit = (cfg_timeout_frames != '0) && (frame_cnt == cfg_timeout_frames);
    abortable   = (state != IDLE) && (state != FIN);
    motor_phase = (state == WAIT_RUN) || (state == WAIT_STOP);

    // abort outranks timeout, which outranks the normal flow
    if (abort && abortable) begin
      state_nx  = FIN;
      ok_nx     = 1'b0;
      err_nx    = ERR_ABORT;
      m_stop_nx = motor_phase;
    end else if (timeout_hit && (motor_phase || state == WAIT_RES)) begin
      state_nx  = FIN;
      ok_nx     = 1'b0;
      err_nx    = ERR_TIMEOUT;
      m_stop_nx = motor_phase;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state_nx = WAIT_RES;
            iter_nx  = '0;
            ok_nx    = 1'b0;
            err_nx   = ERR_NONE;
          end
        end
        WAIT_RES: begin
          if (am_pulse) begin
            if (am_ok) begin
              state_nx = FIN;
              ok_nx    = 1'b1;
              err_nx   = ERR_NONE;
            end else if (am_should_start && (am_step != '0)) begin
              state_nx    = ISSUE;
              step_lat_nx = am_step;
            end
          end
        end
        ISSUE: begin
          if (iter_cnt == cfg_max_iter) begin
            state_nx = FIN;
            ok_nx    = 1'b0;
            err_nx   = ERR_ITER;
          end else begin
            state_nx   = WAIT_RUN;
            m_start_nx = 1'b1;
            m_step_nx  = step_lat;
            iter_nx    = iter_cnt + 1'b1;
          end
        end
        WAIT_RUN:  if (m_state)  state_nx = WAIT_STOP;
        WAIT_STOP: if (!m_state) state_nx = SETTLE;
        SETTLE:    if (frame_cnt >= cfg_settle_frames) state_nx = WAIT_RES;
        FIN: begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default:   state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE);

    // the frame count restarts in every state, so each wait measures only its own frames
    if (state_nx != state)
      frame_cnt_nx = '0;
    else if (img_pulse && (frame_cnt != '1))
      frame_cnt_nx = frame_cnt + 1'b1;
    else
      frame_cnt_nx = frame_cnt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      frame_cnt <= '0;
      step_lat  <= '0;
      m_start   <= 1'b0;
      m_step    <= '0;
      m_stop    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err_code  <= ERR_NONE;
      iter_cnt  <= '0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      step_lat  <= step_lat_nx;
      m_start   <= m_start_nx;
      m_step    <= m_step_nx;
      m_stop    <= m_stop_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      ok        <= ok_nx;
      err_code  <= err_nx;
      iter_cnt  <= iter_nx;
    end
  end

endmodule
